// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache: 8 lines x 4 words, 4-word fill on a read miss.
// Define CACHE_CTRL_STATS_EN to build the read hit/miss counters; without it HIT_NUM and MISS_NUM are tied to 0.
module cache_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_CSN,
    input  logic        REQ_WEN,
    input  logic [11:0] REQ_ADDR,
    input  logic [31:0] REQ_DI,
    output logic [31:0] REQ_DOUT,
    output logic        MISS,
    output logic        D_MEM_CSN,
    output logic        D_MEM_WEN,
    output logic [3:0]  D_MEM_BE,
    output logic [11:0] D_MEM_ADDR,
    output logic [31:0] D_MEM_DOUT,
    input  logic [31:0] D_MEM_DI,
    output logic [31:0] HIT_NUM,
    output logic [31:0] MISS_NUM
);
    // state | meaning
    // IDLE  | serve hits and write-throughs, detect read misses
    // FILL  | cnt 0..3 issue line reads, cnt 1..4 capture returned words
    typedef enum logic {IDLE, FILL} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [9:0]  base_line;
    logic [7:0]  valid;
    logic [6:0]  tag_arr  [8];
    logic [31:0] data_arr [32];

    logic [2:0]  idx;
    logic        hit;
    logic        rd_req;
    logic        wr_req;
    logic [1:0]  fill_word;

    assign idx       = REQ_ADDR[4:2];
    assign hit       = valid[idx] && (tag_arr[idx] == REQ_ADDR[11:5]);
    assign rd_req    = (state == IDLE) && !REQ_CSN && REQ_WEN;
    assign wr_req    = (state == IDLE) && !REQ_CSN && !REQ_WEN;
    assign fill_word = cnt[1:0] - 2'd1;

    always_comb begin
        REQ_DOUT   = '0;
        MISS       = 1'b0;
        D_MEM_CSN  = 1'b1;
        D_MEM_WEN  = 1'b1;
        D_MEM_BE   = '0;
        D_MEM_ADDR = '0;
        D_MEM_DOUT = '0;
        if (!RST) begin
            if (state == FILL) begin
                MISS = 1'b1;
                if (!cnt[2]) begin
                    D_MEM_CSN  = 1'b0;
                    D_MEM_ADDR = {base_line, cnt[1:0]};
                end
            end else if (rd_req) begin
                if (hit) REQ_DOUT = data_arr[{idx, REQ_ADDR[1:0]}];
                else     MISS     = 1'b1;
            end else if (wr_req) begin
                D_MEM_CSN  = 1'b0;
                D_MEM_WEN  = 1'b0;
                D_MEM_BE   = 4'b1111;
                D_MEM_ADDR = REQ_ADDR;
                D_MEM_DOUT = REQ_DI;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req && !hit) begin
                        state     <= FILL;
                        cnt       <= '0;
                        base_line <= REQ_ADDR[11:2];
                    end
                end
                FILL: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd4) begin
                        valid[base_line[2:0]] <= 1'b1;
                        state                 <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (wr_req && hit)
                data_arr[{idx, REQ_ADDR[1:0]}] <= REQ_DI;
            if (state == FILL && cnt != 3'd0)
                data_arr[{base_line[2:0], fill_word}] <= D_MEM_DI;
            if (state == FILL && cnt == 3'd4)
                tag_arr[base_line[2:0]] <= base_line[9:3];
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic        replay;

    // The first IDLE cycle after a fill re-presents the missed request; it is not a new hit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            replay   <= 1'b0;
        end else begin
            replay <= (state == FILL) && (cnt == 3'd4);
            if (rd_req && hit && !replay) hit_cnt  <= hit_cnt + 32'd1;
            if (rd_req && !hit)           miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign HIT_NUM  = hit_cnt;
    assign MISS_NUM = miss_cnt;
`else
    assign HIT_NUM  = '0;
    assign MISS_NUM = '0;
`endif

endmodule
